// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: fetch/LSU request ports plus the byte-wide memory bus.
// master = mem_ctrl side; slave = IF/LSU requesters and the RAM/HCI side.
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_len;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_done, if_data,
    input  ls_req, ls_wr, ls_len, ls_addr, ls_wdata,
    output ls_done, ls_rdata,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_done, if_data,
    output ls_req, ls_wr, ls_len, ls_addr, ls_wdata,
    input  ls_done, ls_rdata,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises fetch words and LSU accesses into byte beats.
// Ports: clk_in, rst_in (sync, high), rdy_in (bus grant), bus (mem_ctrl_if.master).
module mem_ctrl #(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  mem_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_e;
  state_e state_q, state_d;

  logic        src_ls_q;
  logic [31:0] addr_q;
  logic [2:0]  n_q;
  logic [31:0] wdata_q;
  logic        io_q;
  logic [2:0]  iss_q;
  logic        bus_v_q;
  logic [31:0] mem_a_q;
  logic        mem_wr_q;
  logic [7:0]  mem_dout_q;
  logic        cap_v_q;
  logic [1:0]  cap_idx_q;
  logic [31:0] rbuf_q;
  logic        if_done_q;
  logic        ls_done_q;
  logic [31:0] if_data_q;
  logic [31:0] ls_rdata_q;

  logic        done_now;
  logic        start_ls;
  logic        start_if;
  logic        blk;
  logic        beat_ok;
  logic        gap;
  logic        flush_rd;
  logic        last_cap;
  logic        wr_fin;
  logic        pres;
  logic [2:0]  nxt_iss;
  logic [2:0]  req_n;
  logic        req_io;
  logic [31:0] rword;

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ls)      state_d = bus.ls_wr ? WR : RD;
        else if (start_if) state_d = RD;
      end
      RD: if (flush_rd | last_cap) state_d = IDLE;
      WR: if (wr_fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus beat on mem_a in a cycle is issued only if the grant is
  // present (and, for I/O writes, the HCI buffer has room).
  always_comb begin
    done_now = if_done_q | ls_done_q;
    start_ls = (state_q == IDLE) & ~done_now & bus.ls_req;
    start_if = (state_q == IDLE) & ~done_now & ~bus.ls_req
             & bus.if_req & ~bus.if_flush;
    unique case (bus.ls_len)
      2'b00:   req_n = 3'd1;
      2'b01:   req_n = 3'd2;
      default: req_n = 3'd4;
    endcase
    req_io   = bus.ls_addr[RAM_ADDR_WIDTH -: 2] == 2'b11;
    blk      = (state_q == WR) & io_q & bus.io_buffer_full;
    beat_ok  = bus_v_q & rdy_in & ~blk;
    nxt_iss  = iss_q + {2'b00, beat_ok};
    gap      = beat_ok & io_q & (state_q == WR);
    flush_rd = (state_q == RD) & ~src_ls_q & bus.if_flush;
    last_cap = (state_q == RD) & cap_v_q & ~flush_rd
             & (cap_idx_q == 2'(n_q - 3'd1));
    wr_fin   = (state_q == WR) & (nxt_iss == n_q);
    pres     = (state_q != IDLE) & ~flush_rd & ~gap & (nxt_iss < n_q);
    rword    = rbuf_q;
    rword[{cap_idx_q, 3'b000} +: 8] = bus.mem_din;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_ls_q   <= 1'b0;
      addr_q     <= '0;
      n_q        <= '0;
      wdata_q    <= '0;
      io_q       <= 1'b0;
      iss_q      <= '0;
      bus_v_q    <= 1'b0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= '0;
      cap_v_q    <= 1'b0;
      cap_idx_q  <= '0;
      rbuf_q     <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      bus_v_q    <= pres;
      mem_a_q    <= pres ? addr_q + {29'b0, nxt_iss} : '0;
      mem_wr_q   <= pres & (state_q == WR);
      mem_dout_q <= (pres & (state_q == WR))
                  ? wdata_q[{nxt_iss[1:0], 3'b000} +: 8] : '0;
      iss_q      <= nxt_iss;
      cap_v_q    <= (state_q == RD) & beat_ok & ~flush_rd;
      cap_idx_q  <= iss_q[1:0];
      if (cap_v_q & (state_q == RD)) rbuf_q <= rword;
      if_done_q  <= last_cap & ~src_ls_q;
      ls_done_q  <= (last_cap & src_ls_q) | wr_fin;
      if (last_cap & ~src_ls_q) if_data_q  <= rword;
      if (last_cap & src_ls_q)  ls_rdata_q <= rword;
      if (start_ls | start_if) begin
        src_ls_q <= start_ls;
        addr_q   <= start_ls ? bus.ls_addr : bus.if_addr;
        n_q      <= start_ls ? req_n : 3'd4;
        wdata_q  <= bus.ls_wdata;
        io_q     <= start_ls & req_io;
        iss_q    <= '0;
        cap_v_q  <= 1'b0;
        rbuf_q   <= '0;
      end
    end
  end

  assign bus.mem_a    = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_wr   = mem_wr_q & rdy_in & ~(io_q & bus.io_buffer_full);
  assign bus.if_done  = if_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.ls_rdata = ls_rdata_q;
endmodule
